// File: rtl/seq_mult8_pkg.sv
// Shared types and constants for the seq_mult8 shift-and-add multiplier.
package seq_mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult8_if.sv
// Start/operand/result bundle between a requester and seq_mult8.
interface seq_mult8_if #(
  parameter int WIDTH = seq_mult_pkg::WIDTH_DEF
) ();
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult8_add8.sv
// Combinational ripple-carry adder built as a chain of full-adder cells.
module seq_mult8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);
  logic [WIDTH:0] carry_s;

  assign carry_s[0] = Ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    seq_mult8_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_s[i]),
      .s  (S[i]),
      .co (carry_s[i+1])
    );
  end

  assign Co = carry_s[WIDTH];
endmodule

// File: rtl/seq_mult8.sv
// Sequential shift-and-add unsigned multiplier, one partial product per clock.
// Define SEQ_MULT8_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult8
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult8_if.slave     bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 c_q, c_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     sum_s;
  logic                 co_s;
  logic [WIDTH:0]       pre_s;
  logic                 early_s;
  logic                 exit_s;
  logic [CNT_W-1:0]     shamt_s;
  logic [2*WIDTH-1:0]   prod_full_s;

  add8 #(.WIDTH(WIDTH)) u_add (
    .A  (acc_q),
    .B  (m_q),
    .Ci (1'b0),
    .S  (sum_s),
    .Co (co_s)
  );

`ifdef SEQ_MULT8_EARLY_EXIT_EN
  logic [WIDTH-1:0] low_mask_s;
  assign low_mask_s = {WIDTH{1'b1}} >> cnt_q;
  assign early_s    = ((q_q & low_mask_s) == {WIDTH{1'b0}});
`else
  assign early_s = 1'b0;
`endif

  // Partial product sits left-aligned in {ACC,Q}; right-align it for the result.
  assign pre_s       = q_q[0] ? {co_s, sum_s} : {c_q, acc_q};
  assign exit_s      = (cnt_q == CNT_W'(WIDTH)) || early_s;
  assign shamt_s     = CNT_W'(WIDTH) - cnt_q;
  assign prod_full_s = {acc_q, q_q} >> shamt_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      c_q       <= 1'b0;
      q_q       <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CALC;
        else           state_d = IDLE;
      end
      CALC: begin
        if (exit_s) state_d = DONE;
        else        state_d = CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered output values.
  always_comb begin
    m_d       = m_q;
    acc_d     = acc_q;
    c_d       = c_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d   = bus.a;
          q_d   = bus.b;
          acc_d = {WIDTH{1'b0}};
          c_d   = 1'b0;
          cnt_d = {CNT_W{1'b0}};
        end else begin
          m_d   = m_q;
        end
      end
      CALC: begin
        if (exit_s) begin
          product_d = prod_full_s;
        end else begin
          {c_d, acc_d, q_d} = {1'b0, pre_s, q_q[WIDTH-1:1]};
          cnt_d             = cnt_q + CNT_W'(1);
        end
      end
      DONE:    product_d = product_q;
      default: product_d = product_q;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
